// File: rtl/spi_target.sv
// SPI target endpoint: oversamples host SCLK/CS_N/MOSI in the core clock domain,
// shifts words in all four CPOL/CPHA modes and buffers TX/RX words in small FIFOs.

module spi_target_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         push, pop;

  // Pointers carry one wrap bit so full and empty can be told apart.
  assign out_valid = (wr_ptr != rd_ptr);
  assign in_ready  = ((wr_ptr ^ rd_ptr) != {1'b1, {AW{1'b0}}});
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end
endmodule

// state  | meaning
// IDLE   | CS inactive (or not yet seen falling since reset); SCLK ignored
// ACTIVE | frame in progress; shift/sample edges move TX and RX data
module spi_target #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              rst_n,
  input  logic              clk,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              rx_overflow_o,
  output logic              tx_underrun_o,
  input  logic              clr_flags_i
);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W-1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_d, cs_d;
  logic sclk_s, cs_s, mosi_s;

  // CS chain resets low so a CS already held low after reset never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic cpol_q, cpha_q, lsb_q, skip_q;
  logic [IDX_W-1:0]  bit_idx, rx_cnt, bit_sel;
  logic [DATA_W-1:0] tx_byte, rx_shreg, rx_next;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic shift_edge, sample_edge;
  logic frame_start, frame_end, do_shift, do_sample;
  logic tx_load, rx_push, underrun_set, overflow_set;
  logic [DATA_W-1:0] tx_head;
  logic tx_head_valid, rx_in_ready;

  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;
  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    do_shift    = 1'b0;
    do_sample   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end else begin
          do_shift  = shift_edge;
          do_sample = sample_edge;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The word after the last bit is fetched on the wrapping shift edge itself.
  assign tx_load      = frame_start | (do_shift & ~skip_q & (bit_idx == LAST_IDX));
  assign underrun_set = tx_load & ~tx_head_valid;
  assign rx_next      = lsb_q ? {mosi_s, rx_shreg[DATA_W-1:1]}
                              : {rx_shreg[DATA_W-2:0], mosi_s};
  assign rx_push      = do_sample & (rx_cnt == LAST_IDX);
  assign overflow_set = rx_push & ~rx_in_ready;
  assign bit_sel      = lsb_q ? bit_idx : (LAST_IDX - bit_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      lsb_q         <= 1'b0;
      skip_q        <= 1'b0;
      bit_idx       <= '0;
      rx_cnt        <= '0;
      rx_shreg      <= '0;
      tx_byte       <= '0;
      spi_miso_o    <= 1'b0;
      rx_overflow_o <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      if (frame_start) begin
        cpol_q  <= cpol_i;
        cpha_q  <= cpha_i;
        lsb_q   <= lsb_first_i;
        skip_q  <= cpha_i;
        bit_idx <= '0;
        rx_cnt  <= '0;
      end else if (frame_end) begin
        skip_q  <= 1'b0;
        bit_idx <= '0;
        rx_cnt  <= '0;
      end else begin
        if (do_shift) begin
          if (skip_q)                    skip_q  <= 1'b0;
          else if (bit_idx == LAST_IDX)  bit_idx <= '0;
          else                           bit_idx <= bit_idx + IDX_W'(1);
        end
        if (do_sample) begin
          rx_shreg <= rx_next;
          rx_cnt   <= (rx_cnt == LAST_IDX) ? '0 : rx_cnt + IDX_W'(1);
        end
      end

      if (tx_load) tx_byte <= tx_head_valid ? tx_head : '1;

      spi_miso_o <= (state_q == ACTIVE) ? tx_byte[bit_sel] : 1'b0;

      if (overflow_set)     rx_overflow_o <= 1'b1;
      else if (clr_flags_i) rx_overflow_o <= 1'b0;
      if (underrun_set)     tx_underrun_o <= 1'b1;
      else if (clr_flags_i) tx_underrun_o <= 1'b0;
    end
  end

  assign busy_o        = (state_q == ACTIVE);
  assign spi_miso_oe_o = (state_q == ACTIVE);

  spi_target_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (tx_data_i),
    .in_valid  (tx_valid_i),
    .in_ready  (tx_ready_o),
    .out_data  (tx_head),
    .out_valid (tx_head_valid),
    .out_ready (tx_load)
  );

  spi_target_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (rx_next),
    .in_valid  (rx_push),
    .in_ready  (rx_in_ready),
    .out_data  (rx_data_o),
    .out_valid (rx_valid_o),
    .out_ready (rx_ready_i)
  );
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a bit-banged SPI host plus a table of single-word
// mode vectors and hand-written sequences for underrun, overflow, abort and reset.
`timescale 1ns/1ps
module tb_spi_target;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready = 1'b0;
  logic       busy, rx_ovf, tx_und, clr_flags = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] host_tx [8];
  logic [7:0] host_rx [8];
  logic       oe_seen;
  logic       found;

  typedef struct {
    logic cpol, cpha, lsb;
    logic [7:0] tx, mosi_byte, exp_host, exp_rx;
  } vec_t;
  vec_t vecs [5];

  spi_target dut (
    .rst_n         (rst_n),
    .clk           (clk),
    .spi_sclk_i    (sclk),
    .spi_cs_n_i    (cs_n),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (miso_oe),
    .cpol_i        (cpol),
    .cpha_i        (cpha),
    .lsb_first_i   (lsb_first),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .busy_o        (busy),
    .rx_overflow_o (rx_ovf),
    .tx_underrun_o (tx_und),
    .clr_flags_i   (clr_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] bit_pos(input int i);
    logic [2:0] k;
    k = 3'(i);
    return lsb_first ? k : (3'd7 - k);
  endfunction

  function automatic logic host_bit(input int i);
    return host_tx[3'(i >> 3)][bit_pos(i)];
  endfunction

  task automatic capture(input int i);
    host_rx[3'(i >> 3)][bit_pos(i)] = miso;
    if (i == 0) oe_seen = miso_oe & busy;
  endtask

  task automatic host_xfer(input int nbits);
    for (int b = 0; b < 8; b++) host_rx[b] = 8'h00;
    sclk = cpol;
    wait_clk(4);
    cs_n = 1'b0;
    if (!cpha) mosi = host_bit(0);
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      sclk = ~cpol;
      if (!cpha) capture(i);
      else       mosi = host_bit(i);
      wait_clk(H);
      sclk = cpol;
      if (!cpha) begin
        if (i + 1 < nbits) mosi = host_bit(i + 1);
      end else begin
        capture(i);
      end
      wait_clk(H);
    end
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic expect_rx(input string name, input logic [7:0] exp);
    int t;
    t = 0;
    while (!rx_valid && t < 50) begin
      wait_clk(1);
      t++;
    end
    if (!rx_valid) begin
      check({name, "_valid"}, 8'(rx_valid), 8'h01);
    end else begin
      check(name, rx_data, exp);
      rx_ready = 1'b1;
      wait_clk(1);
      rx_ready = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    wait_clk(1);
    clr_flags = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    //            cpol  cpha  lsb   tx     mosi   host   rx
    vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h81, 8'h01, 8'h81, 8'h01};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h81, 8'h01, 8'h81, 8'h01};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h01, 8'h81, 8'h01};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h80, 8'h01, 8'h80, 8'h01};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h80, 8'h01, 8'h80, 8'h01};

    wait_clk(3);
    check("rst_miso", 8'(miso), 8'h00);
    check("rst_oe", 8'(miso_oe), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_tx_ready", 8'(tx_ready), 8'h01);
    check("rst_rx_valid", 8'(rx_valid), 8'h00);
    check("rst_flags", {6'd0, rx_ovf, tx_und}, 8'h00);
    rst_n = 1'b1;
    wait_clk(4);

    // Mode 0, MSB first, two words. The trailing edge that closes the second word
    // fetches a third, so a filler word keeps the underrun flag clear.
    push_tx(8'hA5);
    push_tx(8'h3C);
    push_tx(8'h00);
    host_tx[0] = 8'h5A;
    host_tx[1] = 8'hC3;
    host_xfer(16);
    check("m0_host0", host_rx[0], 8'hA5);
    check("m0_host1", host_rx[1], 8'h3C);
    check("m0_oe_busy", 8'(oe_seen), 8'h01);
    expect_rx("m0_rx0", 8'h5A);
    expect_rx("m0_rx1", 8'hC3);
    check("m0_flags", {6'd0, rx_ovf, tx_und}, 8'h00);
    check("m0_rx_empty", 8'(rx_valid), 8'h00);

    for (int v = 0; v < 5; v++) begin
      cpol = vecs[v].cpol;
      cpha = vecs[v].cpha;
      lsb_first = vecs[v].lsb;
      wait_clk(2);
      push_tx(vecs[v].tx);
      if (!vecs[v].cpha) push_tx(8'h00);
      host_tx[0] = vecs[v].mosi_byte;
      host_xfer(8);
      check($sformatf("vec%0d_host", v), host_rx[0], vecs[v].exp_host);
      expect_rx($sformatf("vec%0d_rx", v), vecs[v].exp_rx);
      check($sformatf("vec%0d_und", v), 8'(tx_und), 8'h00);
    end

    cpol = 1'b0;
    cpha = 1'b0;
    lsb_first = 1'b0;
    pulse_clr();

    // Underrun: empty TX FIFO transmits all ones.
    host_tx[0] = 8'h12;
    host_tx[1] = 8'h34;
    host_xfer(16);
    check("und_host0", host_rx[0], 8'hFF);
    check("und_host1", host_rx[1], 8'hFF);
    expect_rx("und_rx0", 8'h12);
    expect_rx("und_rx1", 8'h34);
    wait_clk(10);
    check("und_sticky", 8'(tx_und), 8'h01);
    pulse_clr();
    check("und_cleared", 8'(tx_und), 8'h00);

    // Overflow: six words into a four-deep RX FIFO that is never popped.
    for (int b = 0; b < 6; b++) host_tx[b] = 8'(b + 1);
    host_xfer(48);
    check("ovf_flag", 8'(rx_ovf), 8'h01);
    for (int b = 0; b < 4; b++) expect_rx($sformatf("ovf_rx%0d", b), 8'(b + 1));
    check("ovf_rx_empty", 8'(rx_valid), 8'h00);
    pulse_clr();
    check("ovf_cleared", 8'(rx_ovf), 8'h00);

    // Overflow while clr_flags_i is held: setting wins, flag remains after release.
    for (int b = 0; b < 4; b++) host_tx[b] = 8'h11 + 8'(b);
    host_xfer(32);
    pulse_clr();
    check("ovfs_pre", 8'(rx_ovf), 8'h00);
    host_tx[0] = 8'h15;
    found = 1'b0;
    fork
      host_xfer(8);
      begin
        clr_flags = 1'b1;
        for (int t = 0; t < 400 && !found; t++) begin
          wait_clk(1);
          if (rx_ovf) found = 1'b1;
        end
        clr_flags = 1'b0;
      end
    join
    check("ovfs_seen", 8'(found), 8'h01);
    wait_clk(5);
    check("ovfs_held", 8'(rx_ovf), 8'h01);
    for (int b = 0; b < 4; b++) expect_rx($sformatf("ovfs_rx%0d", b), 8'h11 + 8'(b));
    pulse_clr();

    // CS abort after five bits: nothing pushed, next frame uses the next TX word.
    push_tx(8'h77);
    push_tx(8'h99);
    push_tx(8'h00);
    host_tx[0] = 8'hF0;
    host_xfer(5);
    check("abort_no_push", 8'(rx_valid), 8'h00);
    host_tx[0] = 8'h96;
    host_xfer(8);
    check("abort_next_host", host_rx[0], 8'h99);
    expect_rx("abort_next_rx", 8'h96);
    check("abort_und", 8'(tx_und), 8'h00);

    // Reset in the middle of a frame with data pending in both FIFOs.
    host_tx[0] = 8'h5C;
    host_xfer(8);
    push_tx(8'hAB);
    push_tx(8'hCD);
    sclk = 1'b0;
    wait_clk(4);
    cs_n = 1'b0;
    mosi = 1'b1;
    wait_clk(H);
    repeat (3) begin
      sclk = 1'b1;
      wait_clk(H);
      sclk = 1'b0;
      wait_clk(H);
    end
    check("rstm_pre_busy", 8'(busy), 8'h01);
    check("rstm_pre_flags", {6'd0, rx_valid, tx_und}, 8'h03);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(1);
    check("rstm_miso", 8'(miso), 8'h00);
    check("rstm_oe_busy", {6'd0, miso_oe, busy}, 8'h00);
    check("rstm_flags", {6'd0, rx_ovf, tx_und}, 8'h00);
    check("rstm_fifos", {6'd0, tx_ready, rx_valid}, 8'h02);
    wait_clk(20);
    check("rstm_wait_fall", 8'(busy), 8'h00);
    cs_n = 1'b1;
    wait_clk(8);
    host_tx[0] = 8'h3E;
    host_xfer(8);
    check("rstm_tx_empty", host_rx[0], 8'hFF);
    check("rstm_und", 8'(tx_und), 8'h01);
    expect_rx("rstm_rx", 8'h3E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
